// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read constants, size encodings and AR channel types for the instruction bridge.
package inst_axi_rd_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned CNT_W  = 2;

  // AXI encodings
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [7:0] ARLEN_SINGLE = 8'd0;

  // sram-like size encodings (log2 bytes)
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  // Latched AR payload
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
  } ar_req_t;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: sram-like fetch requests to single-beat AXI4 reads, in-order returns.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [ID_W-1:0] ARID            = 4'd0
) (
  input  logic              clk,
  input  logic              resetn,
  // sram-like fetch side
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,
  output logic              fetch_err,
  output logic              wr_req_err,
  // AXI AR channel
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // AXI R channel
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ar_state_e        state_q, state_d;
  ar_req_t          ar_q, ar_d;
  logic             arvalid_q, arvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_req_err_q, wr_req_err_d;

  logic accept_c;
  logic rd_done_c;
  logic rready_c;

  // Write-side fetch inputs, rid and rlast carry no meaning for single-beat in-order reads
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  // Handshake qualifiers; acceptance uses the registered count so a same-cycle return cannot free a slot
  always_comb begin
    rready_c  = (cnt_q != '0);
    rd_done_c = rvalid & rready_c;
    accept_c  = (state_q == AR_IDLE) & inst_sram_req & ~inst_sram_wr & (cnt_q < MAX_CNT);
  end

  // Next-state logic: AR FSM, outstanding counter and sticky write-request error
  always_comb begin
    state_d      = state_q;
    ar_d         = ar_q;
    arvalid_d    = arvalid_q;
    cnt_d        = cnt_q;
    wr_req_err_d = wr_req_err_q | (inst_sram_req & inst_sram_wr);

    case (state_q)
      AR_IDLE: begin
        if (accept_c) begin
          ar_d.addr = inst_sram_addr;
          ar_d.size = {1'b0, inst_sram_size};
          arvalid_d = 1'b1;
          state_d   = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = AR_IDLE;
        end
      end
    endcase

    case ({accept_c, rd_done_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= AR_IDLE;
      ar_q         <= '0;
      arvalid_q    <= 1'b0;
      cnt_q        <= '0;
      wr_req_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ar_q         <= ar_d;
      arvalid_q    <= arvalid_d;
      cnt_q        <= cnt_d;
      wr_req_err_q <= wr_req_err_d;
    end
  end

  assign inst_sram_addr_ok = accept_c;
  assign inst_sram_data_ok = rd_done_c;
  assign inst_sram_rdata   = rdata;
  assign fetch_err         = rd_done_c & (rresp != RESP_OKAY);
  assign wr_req_err        = wr_req_err_q;
  assign rready            = rready_c;

  assign arid    = ARID;
  assign araddr  = ar_q.addr;
  assign arlen   = ARLEN_SINGLE;
  assign arsize  = ar_q.size;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: directed scenarios plus randomized traffic against a queue model.
module tb_inst_axi_rd_bridge;
  import inst_axi_rd_bridge_pkg::*;

  localparam int unsigned MAX = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        fetch_err, wr_req_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  // Reference model: pending AR (accepted, not handshaked), issued reads awaiting data, outstanding count
  logic [31:0] ar_pend[$];
  logic [31:0] hs_pend[$];
  int          m_cnt;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic        m_wr_err;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .ARID(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .fetch_err(fetch_err), .wr_req_err(wr_req_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void model_clear();
    ar_pend.delete();
    hs_pend.delete();
    m_cnt    = 0;
    m_araddr = '0;
    m_arsize = '0;
    m_wr_err = 1'b0;
  endfunction

  task automatic idle_inputs();
    inst_sram_req   = 1'b0;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = SIZE_WORD;
    inst_sram_wstrb = 4'h0;
    inst_sram_addr  = '0;
    inst_sram_wdata = '0;
    arready         = 1'b0;
    rid             = 4'd0;
    rdata           = '0;
    rresp           = RESP_OKAY;
    rlast           = 1'b1;
    rvalid          = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Advance one clock and apply the handshake rules to the model; returns at posedge+1
  task automatic tick();
    logic        a_ok, d_ok, ar_hs, wr_seen;
    logic [31:0] a;
    logic [1:0]  s;
    a_ok    = inst_sram_req && !inst_sram_wr && (ar_pend.size() == 0) && (m_cnt < int'(MAX));
    d_ok    = rvalid && (m_cnt != 0);
    ar_hs   = (ar_pend.size() != 0) && arready;
    wr_seen = inst_sram_req && inst_sram_wr;
    a       = inst_sram_addr;
    s       = inst_sram_size;
    @(posedge clk);
    if (wr_seen) m_wr_err = 1'b1;
    if (ar_hs) hs_pend.push_back(ar_pend.pop_front());
    if (a_ok) begin
      ar_pend.push_back(a);
      m_araddr = a;
      m_arsize = {1'b0, s};
    end
    if (d_ok && hs_pend.size() != 0) void'(hs_pend.pop_front());
    m_cnt = m_cnt + int'(a_ok) - int'(d_ok);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    #3;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %0b exp 0", arvalid); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", araddr); end
    checks++; if (arsize !== 3'b000) begin errors++; $display("FAIL reset_arsize got %b exp 000", arsize); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %0b exp 0", rready); end
    checks++; if (wr_req_err !== 1'b0) begin errors++; $display("FAIL reset_wr_req_err got %0b exp 0", wr_req_err); end
    checks++; if ({inst_sram_addr_ok, inst_sram_data_ok, fetch_err} !== 3'b000) begin errors++; $display("FAIL reset_handshakes got %b exp 000", {inst_sram_addr_ok, inst_sram_data_ok, fetch_err}); end
    checks++; if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin errors++; $display("FAIL ar_constants got %h", {arid, arlen, arburst, arlock, arcache, arprot}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = SIZE_WORD; arready = 1'b1;
    #1;
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL single_addr_ok got %0b exp 1", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0000) begin errors++; $display("FAIL single_ar got v=%0b a=%h exp v=1 a=1c000000", arvalid, araddr); end
    checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL single_arsize got %b exp 010", arsize); end
    tick();
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop got %0b exp 0", arvalid); end
    tick(); tick();
    rvalid = 1'b1; rdata = 32'h0280_0C0C; rresp = RESP_OKAY;
    #1;
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0280_0C0C || fetch_err !== 1'b0) begin errors++; $display("FAIL single_data got ok=%0b d=%h e=%0b exp ok=1 d=02800c0c e=0", inst_sram_data_ok, inst_sram_rdata, fetch_err); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b0 || inst_sram_data_ok !== 1'b0) begin errors++; $display("FAIL single_cnt_zero got rready=%0b ok=%0b exp 0 0", rready, inst_sram_data_ok); end
  endtask

  task automatic test_ar_stall();
    do_reset();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010; arready = 1'b0;
    #1;
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL stall_accept got %0b exp 1", inst_sram_addr_ok); end
    tick();
    inst_sram_addr = 32'h1C00_0014;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0010 || inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d] got v=%0b a=%h aok=%0b exp 1 1c000010 0", i, arvalid, araddr, inst_sram_addr_ok); end
      tick();
    end
    arready = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL stall_handshake got v=%0b aok=%0b exp 1 0", arvalid, inst_sram_addr_ok); end
    tick();
    arready = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0 || inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL stall_resume got v=%0b aok=%0b exp 0 1", arvalid, inst_sram_addr_ok); end
    inst_sram_req = 1'b0;
  endtask

  task automatic test_outstanding_limit();
    logic [31:0] seen[$];
    logic [31:0] a;
    int n_acc;
    logic acc;
    do_reset();
    a = 32'h1C00_0000; n_acc = 0;
    inst_sram_req = 1'b1; inst_sram_addr = a; arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      acc = inst_sram_addr_ok;
      if (arvalid && arready) seen.push_back(araddr);
      if (acc) n_acc++;
      tick();
      if (acc) begin a = a + 32'd4; inst_sram_addr = a; end
    end
    checks++; if (n_acc != 2) begin errors++; $display("FAIL limit_accepts got %0d exp 2", n_acc); end
    checks++; if (seen.size() != 2) begin errors++; $display("FAIL limit_ar_count got %0d exp 2", seen.size()); end
    else begin
      checks++; if (seen[0] !== 32'h1C00_0000 || seen[1] !== 32'h1C00_0004) begin errors++; $display("FAIL limit_ar_order got %h %h exp 1c000000 1c000004", seen[0], seen[1]); end
    end
    rvalid = 1'b1; rdata = 32'h1111_0000;
    #1;
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL limit_full_return got dok=%0b aok=%0b exp 1 0", inst_sram_data_ok, inst_sram_addr_ok); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL limit_after_return got %0b exp 1", inst_sram_addr_ok); end
    inst_sram_req = 1'b0;
    rvalid = 1'b1; rdata = 32'h2222_0004;
    #1;
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h2222_0004) begin errors++; $display("FAIL limit_second_data got ok=%0b d=%h exp 1 22220004", inst_sram_data_ok, inst_sram_rdata); end
    tick();
    rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL limit_drained got rready=%0b exp 0", rready); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040; arready = 1'b1;
    #1; tick();
    inst_sram_req = 1'b0;
    #1; tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0044; rvalid = 1'b1; rdata = 32'hABCD_0040;
    #1;
    checks++; if (inst_sram_addr_ok !== 1'b1 || inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL simul_both got aok=%0b dok=%0b exp 1 1", inst_sram_addr_ok, inst_sram_data_ok); end
    tick();
    inst_sram_req = 1'b0; rvalid = 1'b0;
    #1; tick();
    #1;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL simul_cnt_one got rready=%0b exp 1", rready); end
    rvalid = 1'b1; rdata = 32'hABCD_0044;
    #1; tick();
    rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL simul_cnt_zero got rready=%0b exp 0", rready); end
  endtask

  task automatic test_resp_err();
    do_reset();
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (inst_sram_data_ok !== 1'b0 || fetch_err !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL err_unsolicited got dok=%0b ferr=%0b rready=%0b exp 0 0 0", inst_sram_data_ok, fetch_err, rready); end
    rvalid = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0080; arready = 1'b1;
    #1; tick();
    inst_sram_req = 1'b0;
    #1; tick();
    rvalid = 1'b1;
    #1;
    checks++; if (inst_sram_data_ok !== 1'b1 || fetch_err !== 1'b1) begin errors++; $display("FAIL err_pulse got dok=%0b ferr=%0b exp 1 1", inst_sram_data_ok, fetch_err); end
    tick();
    #1;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", fetch_err); end
    rvalid = 1'b0; rresp = RESP_OKAY;
  endtask

  task automatic test_wr_req();
    do_reset();
    inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1C00_0100; arready = 1'b1;
    #1;
    checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL wr_addr_ok got %0b exp 0", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (arvalid !== 1'b0 || wr_req_err !== 1'b1) begin errors++; $display("FAIL wr_sticky[%0d] got arvalid=%0b err=%0b exp 0 1", i, arvalid, wr_req_err); end
      tick();
    end
    resetn = 1'b0;
    #1;
    checks++; if (wr_req_err !== 1'b0) begin errors++; $display("FAIL wr_err_reset got %0b exp 0", wr_req_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0200; arready = 1'b1;
    #1; tick();
    inst_sram_req = 1'b0;
    #1; tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0204; arready = 1'b0;
    #1; tick();
    inst_sram_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || rready !== 1'b1 || araddr !== 32'h1C00_0204) begin errors++; $display("FAIL areset_pre got v=%0b rr=%0b a=%h exp 1 1 1c000204", arvalid, rready, araddr); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || araddr !== 32'h0 || arsize !== 3'b000) begin errors++; $display("FAIL areset_now got v=%0b rr=%0b a=%h s=%b exp 0 0 0 000", arvalid, rready, araddr, arsize); end
    @(posedge clk);
    #1 resetn = 1'b1;
    model_clear();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0300; arready = 1'b1;
    #1;
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL areset_refetch got %0b exp 1", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0300) begin errors++; $display("FAIL areset_ar got v=%0b a=%h exp 1 1c000300", arvalid, araddr); end
    tick(); tick();
    rvalid = 1'b1; rdata = 32'h0000_0300;
    #1;
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0000_0300) begin errors++; $display("FAIL areset_data got ok=%0b d=%h exp 1 00000300", inst_sram_data_ok, inst_sram_rdata); end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_random();
    logic e_aok, e_dok, e_rr, e_ferr, e_arv;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      inst_sram_req  = 1'($urandom_range(0, 1));
      inst_sram_wr   = ($urandom_range(0, 31) == 0);
      inst_sram_addr = $urandom() & 32'hFFFF_FFFC;
      inst_sram_size = 2'($urandom_range(0, 2));
      arready        = ($urandom_range(0, 2) != 0);
      rresp          = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      if (hs_pend.size() != 0) begin
        rvalid = 1'($urandom_range(0, 1));
        rdata  = data_of(hs_pend[0]);
      end else if (m_cnt == 0) begin
        rvalid = ($urandom_range(0, 7) == 0);
        rdata  = $urandom();
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom();
      end
      #1;
      e_aok  = inst_sram_req && !inst_sram_wr && (ar_pend.size() == 0) && (m_cnt < int'(MAX));
      e_rr   = (m_cnt != 0);
      e_dok  = rvalid && e_rr;
      e_ferr = e_dok && (rresp != RESP_OKAY);
      e_arv  = (ar_pend.size() != 0);
      checks++; if (inst_sram_addr_ok !== e_aok) begin errors++; $display("FAIL rnd_addr_ok cyc=%0d got %0b exp %0b", cyc, inst_sram_addr_ok, e_aok); end
      checks++; if ({inst_sram_data_ok, fetch_err, rready} !== {e_dok, e_ferr, e_rr}) begin errors++; $display("FAIL rnd_r cyc=%0d got %b exp %b", cyc, {inst_sram_data_ok, fetch_err, rready}, {e_dok, e_ferr, e_rr}); end
      if (e_dok) begin
        checks++; if (inst_sram_rdata !== data_of(hs_pend[0])) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h exp %h", cyc, inst_sram_rdata, data_of(hs_pend[0])); end
      end
      checks++; if ({arvalid, araddr, arsize} !== {e_arv, m_araddr, m_arsize}) begin errors++; $display("FAIL rnd_ar cyc=%0d got v=%0b a=%h s=%b exp v=%0b a=%h s=%b", cyc, arvalid, araddr, arsize, e_arv, m_araddr, m_arsize); end
      checks++; if (wr_req_err !== m_wr_err) begin errors++; $display("FAIL rnd_wr_err cyc=%0d got %0b exp %0b", cyc, wr_req_err, m_wr_err); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_single_fetch();
    test_ar_stall();
    test_outstanding_limit();
    test_simultaneous();
    test_resp_err();
    test_wr_req();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
Instruction-side bridge upstream of the IF stage. Accepts the IF stage's sram-like fetch requests (req/addr_ok/data_ok handshake) and turns them into single-beat AXI4 read transactions on the AR/R channels. Returns the read data to IF strictly in request order. Supports a bounded number of outstanding reads, so IF can issue the next pc before the previous instruction returns.

Parameters:
MAX_OUTSTANDING, 2, max reads accepted but not yet returned (1..3).
ARID, 4'd0, constant AXI ID driven on arid.

Ports:
clk  in  1  clock; all state on rising edge.
resetn  in  1  asynchronous, active-low reset.
inst_sram_req  in  1  fetch request valid.
inst_sram_wr  in  1  write flag; must be 0 (see Behaviour).
inst_sram_size  in  2  log2 bytes; copied to arsize[1:0].
inst_sram_wstrb  in  4  unused.
inst_sram_addr  in  32  fetch byte address.
inst_sram_wdata  in  32  unused.
inst_sram_addr_ok  out  1  request accepted this cycle.
inst_sram_data_ok  out  1  read data valid this cycle.
inst_sram_rdata  out  32  returned instruction word.
fetch_err  out  1  pulses with data_ok when rresp != OKAY.
wr_req_err  out  1  sticky; set when req arrives with wr=1.
arid  out  4  = ARID.
araddr  out  32  read address.
arlen  out  8  constant 0.
arsize  out  3  {1'b0, latched size}.
arburst  out  2  constant 2'b01.
arlock, arcache, arprot  out  2/4/3  constant 0.
arvalid  out  1  AR valid.
arready  in  1  AR ready.
rid  in  4  ignored; in-order returns assumed.
rdata  in  32  read data.
rresp  in  2  read response.
rlast  in  1  ignored (single beat).
rvalid  in  1  R valid.
rready  out  1  R ready.

Behaviour:
- Reset (resetn=0, asynchronous): arvalid=0, araddr=0, arsize=0, outstanding count=0, wr_req_err=0. addr_ok, data_ok, fetch_err and rready are all 0.
- AR FSM has two states:
  - AR_IDLE: accept when req & ~wr & (cnt < MAX_OUTSTANDING). Acceptance is combinational: addr_ok=1 in that cycle. On the next edge, latch araddr/arsize, set arvalid=1, go to AR_BUSY.
  - AR_BUSY: arvalid held; araddr/arsize stable. On arvalid&arready, return to AR_IDLE with arvalid=0. addr_ok=0 in AR_BUSY, so at most one AR is pending.
- Request-to-arvalid latency is 1 cycle. Back-to-back acceptance is possible every 2 cycles when arready is high on the first arvalid cycle.
- Outstanding count cnt (2 bits):
  - +1 on addr_ok; -1 on rvalid&rready.
  - Both in the same cycle leave cnt unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- R channel:
  - rready = (cnt != 0).
  - data_ok = rvalid & rready; inst_sram_rdata = rdata (combinational, no added latency).
  - fetch_err = data_ok & (rresp != 2'b00).
  - rvalid while cnt==0 is not acknowledged (rready=0).
- Write request: req&wr gives no addr_ok, sets wr_req_err sticky until reset, and issues no AXI transaction.
- Full (cnt==MAX): addr_ok=0 even in AR_IDLE. If data returns in that same cycle, acceptance still waits one cycle (count is the registered value).
- Cancellation is owned by IF (it discards unwanted data_ok). The bridge returns every accepted read and never drops one.
- Mid-transaction reset: all state cleared immediately. The interconnect is reset by the same resetn, so no AXI cleanup is performed.

Decomposition:
- Shared package: AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00, ARLEN_SINGLE=8'd0) and sram-like size encodings.
- No sub-module needed: the AR FSM and the counter fit in one module. The counter may optionally be a generic up_down_counter if the team already has one.

Test Plan:
- Single fetch: req=1, addr=0x1C000000, arready=1 on first arvalid cycle, rvalid 3 cycles later with rdata=0x02800C0C, rresp=0 -> addr_ok for 1 cycle; arvalid 1 cycle with araddr=0x1C000000, arsize=3'b010; data_ok 1 cycle with rdata=0x02800C0C; cnt back to 0.
- arready stall: arready low for 4 cycles -> arvalid/araddr held stable all 4 cycles, no second addr_ok; handshake on cycle 5.
- Outstanding limit (MAX=2): req held high, rvalid delayed -> exactly 2 addr_ok pulses (0x1C000000, 0x1C000004), no third until the first data_ok. Data returns in order.
- Simultaneous accept/return at cnt=1: addr_ok and data_ok in the same cycle -> cnt stays 1.
- Error paths:
  - rresp=2'b10 -> fetch_err=1 in the data_ok cycle only.
  - req with wr=1 -> no addr_ok, no arvalid, wr_req_err=1 until reset.
- Async reset mid-flight: resetn driven low between clock edges while arvalid=1, cnt=2 -> arvalid=0 and cnt=0 immediately, before the next edge; normal fetch works after release.
